// File: rtl/coax_rx_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : coax_rx_buffer_if
//  Description : Receiver-side and host-side signal bundle for coax_rx_buffer.
//                The master modport drives the receiver outputs and the pop
//                request. The slave modport is the buffer itself.
//  Revision    : 1.0  initial release
// ============================================================================
interface coax_rx_buffer_if #(
  parameter int DEPTH_BITS = 8
);
  // receiver side
  logic                  rx_active;
  logic                  rx_error;
  logic [9:0]            rx_data;
  logic                  rx_strobe;
  // host side
  logic                  read_strobe;
  logic [9:0]            data;
  logic                  empty;
  logic                  full;
  logic [DEPTH_BITS:0]   count;
  logic                  active;
  logic                  error;
  logic [9:0]            error_code;

  modport master (
    output rx_active, rx_error, rx_data, rx_strobe, read_strobe,
    input  data, empty, full, count, active, error, error_code
  );

  modport slave (
    input  rx_active, rx_error, rx_data, rx_strobe, read_strobe,
    output data, empty, full, count, active, error, error_code
  );
endinterface
`default_nettype wire

// File: rtl/coax_rx_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : coax_rx_buffer
//  Description : Frame FIFO behind the coax receiver. Stores each strobed
//                10-bit word of a frame, tracks the frame lifecycle
//                (IDLE/RECEIVING/DONE/ERROR) and latches the receiver error
//                code or the local overflow code. Host pops with read_strobe.
//  Revision    : 1.0  initial release
// ============================================================================
module coax_rx_buffer #(
  parameter int DEPTH_BITS = 8
) (
  input  logic             clk,
  input  logic             reset,
  coax_rx_buffer_if.slave  bus
);

  localparam int                  DEPTH           = 2 ** DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] c_depth_count   = (DEPTH_BITS + 1)'(DEPTH);
  localparam logic [DEPTH_BITS:0] c_count_one     = (DEPTH_BITS + 1)'(1);
  localparam logic [DEPTH_BITS-1:0] c_ptr_one     = DEPTH_BITS'(1);
  localparam logic [9:0]          c_overflow_code = 10'b0000001000;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RECEIVING = 2'd1,
    DONE      = 2'd2,
    ERROR     = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next_state;

  logic                  r_rx_active_q;
  logic                  r_rx_error_q;
  logic [DEPTH_BITS-1:0] r_wr_ptr;
  logic [DEPTH_BITS-1:0] r_rd_ptr;
  logic [DEPTH_BITS:0]   r_count;
  logic [9:0]            r_data;
  logic [9:0]            r_error_code;
  logic                  r_active;
  logic                  r_error;
  logic [9:0]            r_mem [DEPTH];

  logic                  w_rise_active;
  logic                  w_fall_active;
  logic                  w_rise_error;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_write;
  logic                  w_flush;
  logic                  w_code_load;
  logic [9:0]            w_code_next;

  assign w_rise_active = bus.rx_active & ~r_rx_active_q;
  assign w_fall_active = ~bus.rx_active & r_rx_active_q;
  assign w_rise_error  = bus.rx_error & ~r_rx_error_q;
  assign w_empty       = (r_count == '0);
  assign w_full        = (r_count == c_depth_count);
  // A frame start flushes the FIFO, so a same-cycle pop has nothing to pop.
  assign w_pop         = bus.read_strobe & ~w_empty & ~w_rise_active;

  // State register and receiver level history for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_rx_active_q <= 1'b0;
      r_rx_error_q  <= 1'b0;
      r_active      <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_rx_active_q <= bus.rx_active;
      r_rx_error_q  <= bus.rx_error;
      r_active      <= (w_next_state == RECEIVING);
      r_error       <= (w_next_state == ERROR);
    end
  end

  // Frame lifecycle: next state, write enable, flush and error-code update.
  always_comb begin
    w_next_state = r_state;
    w_write      = 1'b0;
    w_flush      = 1'b0;
    w_code_load  = 1'b0;
    w_code_next  = r_error_code;
    if (w_rise_active) begin
      w_next_state = RECEIVING;
      w_flush      = 1'b1;
      w_code_load  = 1'b1;
      w_code_next  = 10'd0;
    end else if (r_state == RECEIVING) begin
      // Receiver error wins over a same-cycle drop of rx_active.
      if (w_rise_error) begin
        w_next_state = ERROR;
        w_code_load  = 1'b1;
        w_code_next  = bus.rx_data;
      end else if (bus.rx_strobe && w_full && !w_pop) begin
        w_next_state = ERROR;
        w_code_load  = 1'b1;
        w_code_next  = c_overflow_code;
      end else begin
        w_write = bus.rx_strobe;
        if (w_fall_active) begin
          w_next_state = DONE;
        end
      end
    end else if (w_rise_error) begin
      w_next_state = ERROR;
      w_code_load  = 1'b1;
      w_code_next  = bus.rx_data;
    end
  end

  // Pointers, occupancy count, latched error code.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_error_code <= 10'd0;
    end else begin
      if (w_code_load) begin
        r_error_code <= w_code_next;
      end
      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_write) begin
          r_wr_ptr <= r_wr_ptr + c_ptr_one;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + c_ptr_one;
        end
        case ({w_write, w_pop})
          2'b10:   r_count <= r_count + c_count_one;
          2'b01:   r_count <= r_count - c_count_one;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Word storage; no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (w_write) begin
      r_mem[r_wr_ptr] <= bus.rx_data;
    end
  end

  // Registered read port. On a full-FIFO write+pop the head is read before
  // the same location is overwritten.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data <= 10'd0;
    end else if (w_pop) begin
      r_data <= r_mem[r_rd_ptr];
    end
  end

  assign bus.data       = r_data;
  assign bus.empty      = w_empty;
  assign bus.full       = w_full;
  assign bus.count      = r_count;
  assign bus.active     = r_active;
  assign bus.error      = r_error;
  assign bus.error_code = r_error_code;

endmodule
`default_nettype wire

// File: tb/tb_coax_rx_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_coax_rx_buffer
//  Description : Directed vector bench for coax_rx_buffer with a 4-word FIFO.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_coax_rx_buffer;

  localparam int DEPTH_BITS = 2;
  localparam int DEPTH      = 2 ** DEPTH_BITS;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  coax_rx_buffer_if #(.DEPTH_BITS(DEPTH_BITS)) bus ();

  coax_rx_buffer #(.DEPTH_BITS(DEPTH_BITS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       act;
    logic       err;
    logic [9:0] rxd;
    logic       stb;
    logic       rd;
    logic [9:0] edata;
    int         ecnt;
    logic       eact;
    logic       eerr;
    logic [9:0] ecode;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic act, input logic err, input logic [9:0] rxd,
                     input logic stb, input logic rd, input logic [9:0] edata,
                     input int ecnt, input logic eact, input logic eerr,
                     input logic [9:0] ecode);
    vec_t v;
    v.act = act; v.err = err; v.rxd = rxd; v.stb = stb; v.rd = rd;
    v.edata = edata; v.ecnt = ecnt; v.eact = eact; v.eerr = eerr; v.ecode = ecode;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
  endtask

  task automatic drive(input logic act, input logic err, input logic [9:0] rxd,
                       input logic stb, input logic rd);
    bus.rx_active   = act;
    bus.rx_error    = err;
    bus.rx_data     = rxd;
    bus.rx_strobe   = stb;
    bus.read_strobe = rd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [9:0] edata, input int ecnt,
                           input logic eact, input logic eerr, input logic [9:0] ecode);
    check({tag, ".data"},       int'(bus.data),       int'(edata));
    check({tag, ".count"},      int'(bus.count),      ecnt);
    check({tag, ".empty"},      int'(bus.empty),      int'(ecnt == 0));
    check({tag, ".full"},       int'(bus.full),       int'(ecnt == DEPTH));
    check({tag, ".active"},     int'(bus.active),     int'(eact));
    check({tag, ".error"},      int'(bus.error),      int'(eerr));
    check({tag, ".error_code"}, int'(bus.error_code), int'(ecode));
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;

    // act err rxd     stb rd  data    cnt act err code
    // normal frame
    add(1, 0, 10'h000, 0, 0, 10'h000, 0, 1, 0, 10'h000);
    add(1, 0, 10'h001, 1, 0, 10'h000, 1, 1, 0, 10'h000);
    add(1, 0, 10'h2A5, 1, 0, 10'h000, 2, 1, 0, 10'h000);
    add(1, 0, 10'h3FF, 1, 0, 10'h000, 3, 1, 0, 10'h000);
    add(0, 0, 10'h000, 0, 0, 10'h000, 3, 0, 0, 10'h000);
    add(0, 0, 10'h000, 0, 1, 10'h001, 2, 0, 0, 10'h000);
    add(0, 0, 10'h000, 0, 1, 10'h2A5, 1, 0, 0, 10'h000);
    add(0, 0, 10'h000, 0, 1, 10'h3FF, 0, 0, 0, 10'h000);
    add(0, 0, 10'h000, 0, 1, 10'h3FF, 0, 0, 0, 10'h000);
    // receiver error coinciding with rx_active drop
    add(1, 0, 10'h000, 0, 0, 10'h3FF, 0, 1, 0, 10'h000);
    add(1, 0, 10'h155, 1, 0, 10'h3FF, 1, 1, 0, 10'h000);
    add(0, 1, 10'h002, 0, 0, 10'h3FF, 1, 0, 1, 10'h002);
    add(0, 1, 10'h002, 0, 1, 10'h155, 0, 0, 1, 10'h002);
    add(0, 1, 10'h0AA, 1, 0, 10'h155, 0, 0, 1, 10'h002);
    add(0, 0, 10'h000, 0, 0, 10'h155, 0, 0, 1, 10'h002);
    // overflow without read
    add(1, 0, 10'h000, 0, 0, 10'h155, 0, 1, 0, 10'h000);
    add(1, 0, 10'h010, 1, 0, 10'h155, 1, 1, 0, 10'h000);
    add(1, 0, 10'h011, 1, 0, 10'h155, 2, 1, 0, 10'h000);
    add(1, 0, 10'h012, 1, 0, 10'h155, 3, 1, 0, 10'h000);
    add(1, 0, 10'h013, 1, 0, 10'h155, 4, 1, 0, 10'h000);
    add(1, 0, 10'h014, 1, 0, 10'h155, 4, 0, 1, 10'h008);
    add(0, 0, 10'h000, 0, 0, 10'h155, 4, 0, 1, 10'h008);
    // frame start with read asserted: flush, read ignored
    add(1, 0, 10'h000, 0, 1, 10'h155, 0, 1, 0, 10'h000);
    // full + pop on 5th strobe: no overflow
    add(1, 0, 10'h020, 1, 0, 10'h155, 1, 1, 0, 10'h000);
    add(1, 0, 10'h021, 1, 0, 10'h155, 2, 1, 0, 10'h000);
    add(1, 0, 10'h022, 1, 0, 10'h155, 3, 1, 0, 10'h000);
    add(1, 0, 10'h023, 1, 0, 10'h155, 4, 1, 0, 10'h000);
    add(1, 0, 10'h024, 1, 1, 10'h020, 4, 1, 0, 10'h000);
    add(0, 0, 10'h000, 0, 0, 10'h020, 4, 0, 0, 10'h000);
    add(0, 0, 10'h000, 0, 1, 10'h021, 3, 0, 0, 10'h000);
    add(0, 0, 10'h000, 0, 1, 10'h022, 2, 0, 0, 10'h000);
    add(0, 0, 10'h000, 0, 1, 10'h023, 1, 0, 0, 10'h000);
    add(0, 0, 10'h000, 0, 1, 10'h024, 0, 0, 0, 10'h000);
    // flush of two unread words left in DONE
    add(1, 0, 10'h000, 0, 0, 10'h024, 0, 1, 0, 10'h000);
    add(1, 0, 10'h030, 1, 0, 10'h024, 1, 1, 0, 10'h000);
    add(1, 0, 10'h031, 1, 0, 10'h024, 2, 1, 0, 10'h000);
    add(0, 0, 10'h000, 0, 0, 10'h024, 2, 0, 0, 10'h000);
    add(1, 0, 10'h000, 0, 1, 10'h024, 0, 1, 0, 10'h000);

    // reset state
    reset = 1'b1;
    drive(0, 0, 10'h000, 0, 0);
    step();
    step();
    check_all("reset", 10'h000, 0, 0, 0, 10'h000);
    reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].act, vecs[i].err, vecs[i].rxd, vecs[i].stb, vecs[i].rd);
      step();
      check_all($sformatf("v%0d", i), vecs[i].edata, vecs[i].ecnt,
                vecs[i].eact, vecs[i].eerr, vecs[i].ecode);
    end

    // wrap-around: 10 words streamed through the 4-deep FIFO with
    // write and pop overlapping, pointers start at 0 after the flush
    drive(1, 0, 10'h100, 1, 0);
    step();
    check_all("wrap.first", 10'h024, 1, 1, 0, 10'h000);
    for (int k = 1; k < 10; k++) begin
      drive(1, 0, 10'(10'h100 + k), 1, 1);
      step();
      check_all($sformatf("wrap.k%0d", k), 10'(10'h100 + k - 1), 1, 1, 0, 10'h000);
    end
    drive(0, 0, 10'h000, 0, 1);
    step();
    check_all("wrap.last", 10'h109, 0, 0, 0, 10'h000);
    drive(0, 0, 10'h000, 0, 1);
    step();
    check_all("wrap.empty_read", 10'h109, 0, 0, 0, 10'h000);

    // receiver error raised while DONE
    drive(0, 1, 10'h3C3, 0, 0);
    step();
    check_all("done_err", 10'h109, 0, 0, 1, 10'h3C3);
    drive(0, 0, 10'h000, 0, 0);
    step();
    check_all("err_hold", 10'h109, 0, 0, 1, 10'h3C3);

    // reset in the middle of a frame
    drive(1, 0, 10'h000, 0, 0);
    step();
    drive(1, 0, 10'h2AA, 1, 0);
    step();
    drive(1, 0, 10'h155, 1, 0);
    step();
    check_all("mid.before", 10'h109, 2, 1, 0, 10'h000);
    reset = 1'b1;
    drive(0, 0, 10'h000, 0, 0);
    step();
    check_all("mid.reset", 10'h000, 0, 0, 0, 10'h000);
    reset = 1'b0;
    drive(0, 0, 10'h111, 1, 0);
    step();
    check_all("idle.strobe", 10'h000, 0, 0, 0, 10'h000);

    // buffer works again after reset
    drive(1, 0, 10'h000, 0, 0);
    step();
    drive(1, 0, 10'h0F0, 1, 0);
    step();
    check_all("post.write", 10'h000, 1, 1, 0, 10'h000);
    drive(1, 0, 10'h000, 0, 1);
    step();
    check_all("post.read", 10'h0F0, 0, 1, 0, 10'h000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/coax_rx_buffer.md
Name: coax_rx_buffer

Overview:
Frame buffer directly downstream of the coax receiver. It consumes the receiver's active/error/data/strobe outputs and stores each received 10-bit word of a frame in a FIFO. It tracks the frame lifecycle and latches the receiver error code or its own overflow code. The host side pops words with a read strobe.

Parameters:
DEPTH_BITS, 8, log2 of FIFO depth; DEPTH = 2**DEPTH_BITS words

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
rx_active  input  1  receiver active level (high while mid-frame)
rx_error  input  1  receiver error level (stays high until receiver reset)
rx_data  input  10  received word when rx_strobe=1; error code when rx_error=1
rx_strobe  input  1  one-cycle pulse, word valid on rx_data
read_strobe  input  1  pop request
data  output  10  popped word, registered
empty  output  1  FIFO holds no words
full  output  1  FIFO holds DEPTH words
count  output  DEPTH_BITS+1  number of words held
active  output  1  high in RECEIVING
error  output  1  high in ERROR
error_code  output  10  latched error code, valid while error=1

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high.
- Reset (takes priority over everything):
  - State goes to IDLE.
  - Read and write pointers and count are 0; empty=1, full=0.
  - data=0, error_code=0, active=0, error=0.
- Edge detection: the block registers rx_active and rx_error for edge detection; both registers clear on reset.
- States: IDLE, RECEIVING, DONE, ERROR.
- Frame start: a rising edge of rx_active, in any state, does all of the following in that cycle:
  - Flushes the FIFO (pointers and count to 0).
  - Clears error_code to 0.
  - Moves the state to RECEIVING.
  - A read_strobe in the same cycle is ignored and data holds its value.
- RECEIVING, rx_strobe=1:
  - If not full, or read_strobe pops in the same cycle: write rx_data and advance the write pointer.
  - Otherwise: error_code <= 10'b0000001000 (overflow), go to ERROR, word dropped.
- RECEIVING, rising edge of rx_error: error_code <= rx_data, go to ERROR. This has priority over a same-cycle falling edge of rx_active, because the receiver drops active and raises error on the same edge.
- RECEIVING, falling edge of rx_active with no rx_error edge: go to DONE.
- In IDLE, DONE and ERROR, rx_strobe is ignored. ERROR persists until the next frame start or reset.
- Rising edge of rx_error outside RECEIVING: error_code <= rx_data, go to ERROR.
- Read:
  - read_strobe with empty=0: data <= head word, visible the cycle after the strobe (latency 1); the read pointer advances.
  - read_strobe with empty=1: ignored; data, pointers and count unchanged.
  - Reads are allowed in every state, so words stored before an error stay readable.
- Count and flags:
  - Simultaneous write and pop: count unchanged, both pointers advance.
  - Pointers wrap modulo DEPTH.
  - count is updated in the same cycle as the write or pop.
  - empty = (count==0), full = (count==DEPTH), both registered or derived from registered count.
- Outputs: active = (state==RECEIVING), error = (state==ERROR), both registered, no glitches.
- Memory: inferred synchronous RAM, DEPTH x 10.

Test Plan:
- Normal frame: rx_active rises, 3 strobes 10'h001/10'h2A5/10'h3FF, then rx_active falls -> state DONE, count=3. Three read_strobes return the words in order, each on the cycle after its strobe; then empty=1, count=0.
- Receiver error: 1 word 10'h155 stored, then rx_active falls in the same cycle rx_error rises with rx_data=10'b0000000010 -> error=1, error_code=10'h002, state ERROR (not DONE). The stored word is still readable and returns 10'h155.
- Overflow (DEPTH_BITS=2): 5 strobes with no reads -> the first 4 words are stored, full=1, count=4; the 5th gives error=1 and error_code=10'h008. Repeat with read_strobe coinciding with the 5th strobe -> no error, count stays 4, the 5th word is stored.
- Flush on new frame: 2 unread words left in DONE, new rx_active rising edge with read_strobe asserted -> count=0, empty=1, error_code=0, active=1, data unchanged.
- Wrap-around (DEPTH_BITS=2): across frames, write and pop 10 words interleaved -> order preserved across pointer wrap; a read_strobe when empty leaves data and count unchanged.
- Reset mid-frame: assert reset during RECEIVING with 2 words stored -> next cycle state IDLE, count=0, empty=1, data=0, active=0, error=0. A strobe while IDLE is ignored.
